// File: rtl/stoch_pkg.sv
// Shared definitions for the stochastic multiplier sequencer: FSM states,
// LFSR geometry, stream-length limits and default seeds.
package stoch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FILL,
    S_RUN,
    S_DONE
  } state_t;

  localparam int unsigned LFSR_W       = 31;
  localparam int unsigned TAP_HI       = 30;
  localparam int unsigned TAP_LO       = 27;
  localparam int unsigned LEN_LOG2_MIN = 3;
  localparam int unsigned PIPE_DEPTH   = 2;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED1 = 31'd1;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED2 = 31'd2;

  function automatic logic [LFSR_W-1:0] lfsr_next(logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
  endfunction

  function automatic logic [3:0] clamp_len(logic [3:0] cfg, logic [3:0] max_l);
    if (cfg < 4'(LEN_LOG2_MIN)) return 4'(LEN_LOG2_MIN);
    if (cfg > max_l)            return max_l;
    return cfg;
  endfunction

endpackage

// File: rtl/stoch_mult_core.sv
// Bipolar stochastic multiplier datapath: two LFSRs feed 4-bit comparators
// (sn1, sn2), whose XNOR is registered into sn_out (pipeline depth 2).
// Ports: clk, rst_n (async, active-high), en (advance datapath),
//        load (reload seeds), a/b (4-bit operands), sn_out (stream bit).
module stoch_mult_core
  import stoch_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED1 = DEFAULT_SEED1,
  parameter logic [LFSR_W-1:0] SEED2 = DEFAULT_SEED2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       sn_out
);

  logic [LFSR_W-1:0] lfsr1_q, lfsr2_q;
  logic              sn1_q, sn2_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      lfsr1_q <= SEED1;
      lfsr2_q <= SEED2;
      sn1_q   <= 1'b0;
      sn2_q   <= 1'b0;
      sn_out  <= 1'b0;
    end else if (load) begin
      lfsr1_q <= SEED1;
      lfsr2_q <= SEED2;
      sn1_q   <= 1'b0;
      sn2_q   <= 1'b0;
      sn_out  <= 1'b0;
    end else if (en) begin
      lfsr1_q <= lfsr_next(lfsr1_q);
      lfsr2_q <= lfsr_next(lfsr2_q);
      sn1_q   <= lfsr1_q[3:0] < a;
      sn2_q   <= lfsr2_q[3:0] < b;
      sn_out  <= ~(sn1_q ^ sn2_q);
    end
  end

endmodule

// File: rtl/stoch_mult_sequencer.sv
// Round-robin arbiter and job sequencer sharing one stochastic multiplier
// among NUM_REQ requesters.
// Ports: clk, rst_n (async, active-high), req_valid/req_ready (per-requester
//        handshake, ready is a one-hot accept pulse), req_a/req_b (4-bit
//        operands per requester), cfg_len_log2 (stream length exponent),
//        busy, res_valid/res_ready (result handshake), res_id, res_ones,
//        res_bipolar (signed 2*ones - N).
module stoch_mult_sequencer
  import stoch_pkg::*;
#(
  parameter int unsigned       NUM_REQ      = 2,
  parameter int unsigned       LEN_LOG2_MAX = 8,
  parameter logic [LFSR_W-1:0] SEED1        = DEFAULT_SEED1,
  parameter logic [LFSR_W-1:0] SEED2        = DEFAULT_SEED2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [4*NUM_REQ-1:0]    req_a,
  input  logic [4*NUM_REQ-1:0]    req_b,
  input  logic [3:0]              cfg_len_log2,
  output logic                    busy,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [1:0]              res_id,
  output logic [LEN_LOG2_MAX:0]   res_ones,
  output logic [LEN_LOG2_MAX+1:0] res_bipolar
);

  localparam int unsigned CW = LEN_LOG2_MAX + 1;
  localparam int unsigned BW = LEN_LOG2_MAX + 2;

  state_t          state_q, state_d;
  logic [3:0]      a_q, b_q, len_q;
  logic [1:0]      rr_q;
  logic [CW-1:0]   ones_q, cyc_q, last_cyc, ones_fin;
  logic [BW-1:0]   bip_fin;
  logic            sn_out;

  logic            grant_any;
  logic [1:0]      grant_idx;
  logic [3:0]      valid_pad, grant_pad;
  logic [3:0]      a_sel, b_sel;

  function automatic logic [1:0] rr_idx(logic [1:0] base, int unsigned off);
    int unsigned s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[1:0];
  endfunction

  // Arbitration only while idle and out of reset, so req_ready reads 0
  // during an asserted reset even if requests are pending.
  always_comb begin
    valid_pad = '0;
    valid_pad[NUM_REQ-1:0] = req_valid;
    grant_any = 1'b0;
    grant_idx = '0;
    if (state_q == S_IDLE && !rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!grant_any && valid_pad[rr_idx(rr_q, i)]) begin
          grant_any = 1'b1;
          grant_idx = rr_idx(rr_q, i);
        end
      end
    end
    grant_pad = '0;
    if (grant_any) grant_pad[grant_idx] = 1'b1;
  end

  assign req_ready = grant_pad[NUM_REQ-1:0];

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == 2'(i)) begin
        a_sel = req_a[4*i +: 4];
        b_sel = req_b[4*i +: 4];
      end
    end
  end

  assign last_cyc = (CW'(1) << len_q) - CW'(1);
  // The final RUN cycle's stream bit is folded in as the result is captured.
  assign ones_fin = ones_q + CW'(sn_out);
  assign bip_fin  = {ones_fin, 1'b0} - (BW'(1) << len_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_any) state_d = S_LOAD;
      S_LOAD:  state_d = S_FILL;
      S_FILL:  if (cyc_q == CW'(PIPE_DEPTH - 1)) state_d = S_RUN;
      S_RUN:   if (cyc_q == last_cyc) state_d = S_DONE;
      S_DONE:  if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      len_q       <= 4'(LEN_LOG2_MIN);
      rr_q        <= '0;
      ones_q      <= '0;
      cyc_q       <= '0;
      res_id      <= '0;
      res_ones    <= '0;
      res_bipolar <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (grant_any) begin
          a_q    <= a_sel;
          b_q    <= b_sel;
          res_id <= grant_idx;
          len_q  <= clamp_len(cfg_len_log2, 4'(LEN_LOG2_MAX));
          rr_q   <= (grant_idx == 2'(NUM_REQ - 1)) ? 2'd0 : grant_idx + 2'd1;
        end
        S_LOAD: begin
          ones_q <= '0;
          cyc_q  <= '0;
        end
        S_FILL: cyc_q <= (state_d == S_RUN) ? '0 : cyc_q + CW'(1);
        S_RUN: begin
          ones_q <= ones_fin;
          cyc_q  <= cyc_q + CW'(1);
          if (state_d == S_DONE) begin
            res_ones    <= ones_fin;
            res_bipolar <= bip_fin;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign res_valid = (state_q == S_DONE);

  stoch_mult_core #(
    .SEED1(SEED1),
    .SEED2(SEED2)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == S_FILL || state_q == S_RUN),
    .load  (state_q == S_LOAD),
    .a     (a_q),
    .b     (b_q),
    .sn_out(sn_out)
  );

endmodule

// File: tb/tb_stoch_mult_sequencer.sv
module tb_stoch_mult_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_a, req_b;
  logic [3:0] cfg_len_log2;
  logic       busy, res_valid, res_ready;
  logic [1:0] res_id;
  logic [8:0] res_ones;
  logic [9:0] res_bipolar;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stoch_mult_sequencer #(
    .NUM_REQ(2),
    .LEN_LOG2_MAX(8),
    .SEED1(31'd1),
    .SEED2(31'd2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .cfg_len_log2(cfg_len_log2), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_ones(res_ones), .res_bipolar(res_bipolar)
  );

  typedef struct {
    int         rid;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] cfg;
    int         exp_ones;
    int         exp_bip;
    int         exp_lat;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: count XNOR agreements of the two comparator streams over
  // the first 2^L LFSR states starting at the seeds.
  function automatic int model_ones(logic [3:0] a, logic [3:0] b, int l);
    logic [30:0] l1 = 31'd1;
    logic [30:0] l2 = 31'd2;
    int n = 0;
    for (int k = 0; k < (1 << l); k++) begin
      if ((l1[3:0] < a) == (l2[3:0] < b)) n++;
      l1 = {l1[29:0], l1[30] ^ l1[27]};
      l2 = {l2[29:0], l2[30] ^ l2[27]};
    end
    return n;
  endfunction

  // Presents a single request, passes the accept edge, ends at the negedge
  // after it with req_valid dropped.
  task automatic start_job(input int rid, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] cfg, output int rdy);
    @(negedge clk);
    req_a = '0;
    req_b = '0;
    req_a[4*rid +: 4] = a;
    req_b[4*rid +: 4] = b;
    req_valid = '0;
    req_valid[rid] = 1'b1;
    cfg_len_log2 = cfg;
    #1 rdy = int'(req_ready);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
  endtask

  // lat counts rising edges from the accept edge (=1) to res_valid.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!res_valid && lat < 600) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic take_result;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic run_job(input int rid, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] cfg, output int rdy, output int lat,
                         output int ones, output int bip, output int id);
    start_job(rid, a, b, cfg, rdy);
    wait_valid(lat);
    ones = int'(res_ones);
    bip  = int'($signed(res_bipolar));
    id   = int'(res_id);
    take_result();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int rdy, lat, ones, bip, id, clean_ones, g, prev;
    int order[4];
    int snap_ones, snap_bip, snap_id, exp_st;

    vecs[0] = '{0, 4'd0, 4'd0, 4'd8,  256, 256, 260};
    vecs[1] = '{1, 4'd0, 4'd0, 4'd2,    8,   8,  12};
    vecs[2] = '{0, 4'd0, 4'd0, 4'd0,    8,   8,  12};
    vecs[3] = '{1, 4'd0, 4'd0, 4'd15, 256, 256, 260};
    vecs[4] = '{0, 4'd0, 4'd0, 4'd5,   32,  32,  36};
    vecs[5] = '{1, 4'd0, 4'd0, 4'd3,    8,   8,  12};
    vecs[6] = '{0, 4'd0, 4'd0, 4'd4,   16,  16,  20};
    order = '{0, 1, 0, 1};

    rst_n = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    cfg_len_log2 = '0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_res_id", int'(res_id), 0);
    check("rst_res_ones", int'(res_ones), 0);
    check("rst_res_bipolar", int'(res_bipolar), 0);
    rst_n = 1'b0;

    // Table-driven jobs
    for (int i = 0; i < 7; i++) begin
      run_job(vecs[i].rid, vecs[i].a, vecs[i].b, vecs[i].cfg, rdy, lat, ones, bip, id);
      check($sformatf("vec%0d_ready", i), rdy, 1 << vecs[i].rid);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_ones", i), ones, vecs[i].exp_ones);
      check($sformatf("vec%0d_bipolar", i), bip, vecs[i].exp_bip);
      check($sformatf("vec%0d_id", i), id, vecs[i].rid);
      check($sformatf("vec%0d_idle_after", i), int'(busy), 0);
    end

    // Round robin with both requesters held high
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    req_a = '0;
    req_b = '0;
    cfg_len_log2 = 4'd3;
    req_valid = 2'b11;
    res_ready = 1'b1;
    g = 0;
    prev = 0;
    for (int c = 0; c < 200 && g < 4; c++) begin
      #1;
      if (req_ready != 2'b00) begin
        check($sformatf("rr_grant%0d", g), int'(req_ready), 1 << order[g]);
        check($sformatf("rr_pulse%0d", g), prev, 0);
        g++;
      end
      prev = int'(req_ready);
      @(negedge clk);
    end
    check("rr_grant_count", g, 4);
    req_valid = '0;
    for (int c = 0; c < 100 && busy; c++) @(negedge clk);
    res_ready = 1'b0;
    check("rr_drain_busy", int'(busy), 0);

    // Result held while consumer stalls
    start_job(1, 4'd3, 4'd7, 4'd3, rdy);
    wait_valid(lat);
    exp_st = model_ones(4'd3, 4'd7, 3);
    check("stall_latency", lat, 12);
    check("stall_ones", int'(res_ones), exp_st);
    check("stall_bipolar", int'($signed(res_bipolar)), 2 * exp_st - 8);
    snap_ones = int'(res_ones);
    snap_bip  = int'(res_bipolar);
    snap_id   = int'(res_id);
    req_valid = 2'b11;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("stall%0d_valid", c), int'(res_valid), 1);
      check($sformatf("stall%0d_busy", c), int'(busy), 1);
      check($sformatf("stall%0d_req_ready", c), int'(req_ready), 0);
      check($sformatf("stall%0d_stable", c),
            int'(res_ones == 9'(snap_ones) && res_bipolar == 10'(snap_bip)
                 && res_id == 2'(snap_id)), 1);
    end
    req_valid = '0;
    take_result();
    check("stall_release_valid", int'(res_valid), 0);
    check("stall_release_busy", int'(busy), 0);

    // Reset in RUN cycle 50, then rerun the same job
    run_job(0, 4'd5, 4'd9, 4'd6, rdy, lat, clean_ones, bip, id);
    check("clean_ones_model", clean_ones, model_ones(4'd5, 4'd9, 6));
    check("clean_latency", lat, 68);
    start_job(0, 4'd5, 4'd9, 4'd6, rdy);
    repeat (52) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_res_valid", int'(res_valid), 0);
    check("midrst_res_ones", int'(res_ones), 0);
    check("midrst_res_bipolar", int'(res_bipolar), 0);
    check("midrst_res_id", int'(res_id), 0);
    @(negedge clk);
    rst_n = 1'b0;
    run_job(0, 4'd5, 4'd9, 4'd6, rdy, lat, ones, bip, id);
    check("rerun_ones_model", ones, model_ones(4'd5, 4'd9, 6));
    check("rerun_ones_clean", ones, clean_ones);
    check("rerun_bipolar", bip, 2 * model_ones(4'd5, 4'd9, 6) - 64);

    // Golden sweep of all operand pairs at full length
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_job(b % 2, 4'(a), 4'(b), 4'd8, rdy, lat, ones, bip, id);
        check($sformatf("sweep_a%0d_b%0d", a, b), ones, model_ones(4'(a), 4'(b), 8));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stoch_mult_sequencer.md
Name: stoch_mult_sequencer

Overview:
Round-robin arbiter and job sequencer that shares one stochastic bipolar multiplier datapath among NUM_REQ requesters. A granted job seeds the two 31-bit LFSRs and latches the 4-bit operand pair. The block runs the comparator/XNOR pipeline for a configurable stream length of 2^L bits and counts the ones. It returns a ones count and a signed bipolar result over a valid/ready handshake tagged with the requester id.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
LEN_LOG2_MAX, 8, maximum stream length exponent
SEED1, 31'd1, LFSR 1 seed loaded at every job start
SEED2, 31'd2, LFSR 2 seed loaded at every job start

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-high (asserted = 1, despite the name)
req_valid  in  NUM_REQ  per-requester job request
req_ready  out  NUM_REQ  one-hot acceptance pulse
req_a  in  4*NUM_REQ  operand A per requester, slice i = [4i+3:4i]
req_b  in  4*NUM_REQ  operand B per requester
cfg_len_log2  in  4  stream length exponent, sampled at accept
busy  out  1  high in any state except IDLE
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_id  out  2  requester index of the result
res_ones  out  LEN_LOG2_MAX+1  count of ones in the output stream
res_bipolar  out  LEN_LOG2_MAX+2  signed, 2*ones - N

Behaviour:
- Reset: FSM=IDLE, req_ready=0, busy=0, res_valid=0, res_id=0, res_ones=0, res_bipolar=0, rr pointer=0, LFSRs=SEED1/SEED2.
- FSM states: IDLE, LOAD, FILL, RUN, DONE.
- IDLE, any req_valid:
  - Grant the first asserted requester at or after the rr pointer, wrapping.
  - Assert req_ready[g] for that cycle only; latch a, b, g.
  - Latch L = clamp(cfg_len_log2, 3, LEN_LOG2_MAX); N = 2^L.
  - Set rr pointer = g+1 mod NUM_REQ. Go to LOAD.
- LOAD (1 cycle): load SEED1/SEED2 into the LFSRs, clear the ones counter and the cycle counter. Go to FILL.
- Datapath (enabled in FILL and RUN):
  - Each LFSR shifts left with feedback bit[30]^bit[27] into bit[0].
  - sn1 <= lfsr1[3:0] < a; sn2 <= lfsr2[3:0] < b (both registered).
  - sn_out <= ~(sn1 ^ sn2) (registered).
  - Pipeline depth is 2.
- FILL (2 cycles): pipeline primes; nothing is counted. Go to RUN.
- RUN (exactly N cycles): ones += sn_out each cycle. The counter is L+1 bits wide and cannot overflow; ones = N is legal. After the Nth cycle go to DONE.
- DONE:
  - res_valid=1; res_id, res_ones and res_bipolar are registered and stable.
  - Leave DONE only on res_valid && res_ready, then return to IDLE. No arbitration takes place in the cycle of that handshake.
  - While res_ready is low, hold all outputs and accept no request.
- Latency: accept at cycle t gives LOAD at t+1, FILL at t+2..t+3, RUN at t+4..t+3+N, and res_valid first high at t+4+N.
- req_valid deasserted after acceptance: no effect. Inputs other than cfg_len_log2, req_a and req_b at accept are ignored mid-job.
- Requester outside NUM_REQ: unused bits of res_id are 0.
- Reset mid-job: immediate return to the reset state; the job is lost and no result is produced. Seeds are deterministic, so a re-run of the same job gives an identical result.

Decomposition:
- Package stoch_pkg holds:
  - FSM state enum.
  - LFSR width 31 and taps 30/27.
  - Minimum length exponent 3.
  - Default seeds.
- Sub-module stoch_mult_core contains:
  - the two LFSRs;
  - the comparators;
  - the XNOR pipeline.
- stoch_mult_core ports: clk, rst_n, en, load, a, b, sn_out.
- Arbiter, FSM and counters stay in stoch_mult_sequencer.

Test Plan:
- Requester 0 with a=0, b=0, cfg=8 → sn1=sn2=0, XNOR=1 every cycle; res_ones=256, res_bipolar=+256, res_id=0, res_valid at accept+260.
- Requester 1 with a=0, b=0, cfg=2 → clamped to L=3; res_ones=8, res_bipolar=+8, res_valid at accept+12.
- Both req_valid held high, res_ready=1, four jobs → grant order 0,1,0,1; each req_ready is a single-cycle one-hot pulse.
- res_ready low for 10 cycles in DONE → res_* stable and req_ready=0 throughout; job resumes on release, and busy stays 1 until DONE exits.
- Reset asserted in RUN cycle 50 → all outputs return to reset values asynchronously. Re-running the job (a=5, b=9, cfg=6) gives res_ones equal to a golden-model LFSR simulation and to a run without the reset.
- Golden sweep: all 256 (a, b) pairs at cfg=8 → res_ones matches a bit-accurate reference model exactly.
